// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the datapath and the pipeline sequencer.
// slave: hazard sources in, register enables/flushes and counters out.
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       rs1_id;
   logic [4:0]       rs2_id;
   logic             rs1_used_id;
   logic             rs2_used_id;
   logic [4:0]       rd_ex;
   logic             mem_read_ex;
   logic             redirect_ex;
   logic             mem_req_mem;
   logic             dmem_ready;
   logic             pc_en;
   logic             if_id_en;
   logic             if_id_flush;
   logic             id_ex_en;
   logic             id_ex_flush;
   logic             ex_mem_en;
   logic             ex_mem_flush;
   logic             mem_wb_en;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output rs1_id, rs2_id, rs1_used_id, rs2_used_id,
      output rd_ex, mem_read_ex, redirect_ex,
      output mem_req_mem, dmem_ready,
      input  pc_en, if_id_en, if_id_flush,
      input  id_ex_en, id_ex_flush,
      input  ex_mem_en, ex_mem_flush, mem_wb_en,
      input  mem_err, stall_cnt, flush_cnt
   );

   modport slave (
      input  rs1_id, rs2_id, rs1_used_id, rs2_used_id,
      input  rd_ex, mem_read_ex, redirect_ex,
      input  mem_req_mem, dmem_ready,
      output pc_en, if_id_en, if_id_flush,
      output id_ex_en, id_ex_flush,
      output ex_mem_en, ex_mem_flush, mem_wb_en,
      output mem_err, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: drives IF/ID..MEM/WB enables/flushes from
// dmem wait (with timeout), EX redirect and load-use; counts stalls/flushes.
// Ports: clk, rst (async, active-high), bus (pipe_hazard_ctrl_if.slave).
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input logic              clk,
   input logic              rst,
   pipe_hazard_ctrl_if.slave bus
);
   typedef enum logic {RUN, MEM_WAIT} state_e;

   localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [15:0]      wait_cnt_q, wait_cnt_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic timeout;
   logic mem_stall;
   logic lu;
   logic rs1_hit, rs2_hit;
   logic pc_en, if_id_en, if_id_flush;
   logic id_ex_en, id_ex_flush;
   logic ex_mem_en, mem_wb_en;

   assign timeout = (wait_cnt_q == TO_LAST);

   assign mem_stall =
      (state_q == RUN && bus.mem_req_mem && !bus.dmem_ready) ||
      (state_q == MEM_WAIT && !bus.dmem_ready && !timeout);

   assign rs1_hit = bus.rs1_used_id && (bus.rs1_id == bus.rd_ex);
   assign rs2_hit = bus.rs2_used_id && (bus.rs2_id == bus.rd_ex);
   assign lu = bus.mem_read_ex && (bus.rd_ex != 5'd0) &&
               (rs1_hit || rs2_hit);

   // Sources overlap, so evaluation order carries the priority.
   always_comb begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      if_id_flush = 1'b0;
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b0;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      priority case (1'b1)
         mem_stall: begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
         end
         bus.redirect_ex: begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end
         lu: begin
            // Hold PC and IF/ID; ID/EX loads a bubble.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      unique case (state_q)
         RUN: begin
            if (bus.mem_req_mem && !bus.dmem_ready) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = '0;
            end
         end
         MEM_WAIT: begin
            if (bus.dmem_ready) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (timeout) begin
               state_d    = RUN;
               wait_cnt_d = '0;
               mem_err_d  = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_en && stall_cnt_q != '1)
         stall_cnt_d = stall_cnt_q + 1'b1;
      if (id_ex_flush && flush_cnt_q != '1)
         flush_cnt_d = flush_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.pc_en        = pc_en;
   assign bus.if_id_en     = if_id_en;
   assign bus.if_id_flush  = if_id_flush;
   assign bus.id_ex_en     = id_ex_en;
   assign bus.id_ex_flush  = id_ex_flush;
   assign bus.ex_mem_en    = ex_mem_en;
   assign bus.ex_mem_flush = 1'b0;
   assign bus.mem_wb_en    = mem_wb_en;
   assign bus.mem_err      = mem_err_q;
   assign bus.stall_cnt    = stall_cnt_q;
   assign bus.flush_cnt    = flush_cnt_q;
endmodule
